// File: rtl/spi_dac_rx_2ch_if.sv
// SPI write-link wires between a DAC writer (master) and the 2-channel DAC responder (slave).
// Optional macro SPI_DAC_RX_LDAC_EN adds the active-low load strobe ldac_i.
interface spi_dac_rx_2ch_if;
  logic sck_i;
  logic cs_i;
  logic mosi_i;
`ifdef SPI_DAC_RX_LDAC_EN
  logic ldac_i;

  modport master (output sck_i, output cs_i, output mosi_i, output ldac_i);
  modport slave  (input  sck_i, input  cs_i, input  mosi_i, input  ldac_i);
`else
  modport master (output sck_i, output cs_i, output mosi_i);
  modport slave  (input  sck_i, input  cs_i, input  mosi_i);
`endif
endinterface

// File: rtl/spi_dac_rx_2ch.sv
// Oversampling SPI responder for the 2-channel DAC link: deserialises {ctrl[3:0], data} frames.
// Optional macro SPI_DAC_RX_LDAC_EN: decoded data is held until a falling edge on ldac_i.
module spi_dac_rx_2ch #(
  parameter int unsigned Width      = 16,
  parameter int unsigned SyncStages = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  spi_dac_rx_2ch_if.slave        spi,
  output logic [Width-5:0]       dcha_o,
  output logic [Width-5:0]       dchb_o,
  output logic                   vlda_o,
  output logic                   vldb_o,
  output logic                   shdna_o,
  output logic                   shdnb_o,
  output logic                   err_o,
  output logic                   busy_o
);

  localparam int unsigned DataW = Width - 4;
  localparam int unsigned CntW  = $clog2(Width + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(Width);
  localparam logic [CntW-1:0] CntMax  = CntW'(Width + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDecode} state_e;

  // Input synchronisers, preset to the idle bus levels
  logic [SyncStages-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic sck_s, cs_s, mosi_s;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SyncStages-2:0], spi.sck_i};
      cs_sync_q   <= {cs_sync_q[SyncStages-2:0], spi.cs_i};
      mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], spi.mosi_i};
    end
  end

  assign sck_s  = sck_sync_q[SyncStages-1];
  assign cs_s   = cs_sync_q[SyncStages-1];
  assign mosi_s = mosi_sync_q[SyncStages-1];

  // Registered edge strobes; mosi_q is delayed alongside so it lines up with sck_rise_q
  logic sck_prev_q, cs_prev_q;
  logic sck_rise_q, cs_fall_q, cs_rise_q, mosi_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
      sck_rise_q <= 1'b0;
      cs_fall_q  <= 1'b0;
      cs_rise_q  <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
      sck_rise_q <= sck_s & ~sck_prev_q;
      cs_fall_q  <= ~cs_s & cs_prev_q;
      cs_rise_q  <= cs_s & ~cs_prev_q;
      mosi_q     <= mosi_s;
    end
  end

`ifdef SPI_DAC_RX_LDAC_EN
  logic [SyncStages-1:0] ldac_sync_q;
  logic ldac_prev_q, ldac_fall_q;
  logic ldac_s;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ldac_sync_q <= '1;
      ldac_prev_q <= 1'b1;
      ldac_fall_q <= 1'b0;
    end else begin
      ldac_sync_q <= {ldac_sync_q[SyncStages-2:0], spi.ldac_i};
      ldac_prev_q <= ldac_s;
      ldac_fall_q <= ~ldac_s & ldac_prev_q;
    end
  end

  assign ldac_s = ldac_sync_q[SyncStages-1];
`endif

  // Frame FSM
  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Width-1:0]  shift_q, shift_d;
  logic              dec_ok, dec_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    dec_ok  = 1'b0;
    dec_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall_q) begin
          state_d = StShift;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StShift: begin
        if (sck_rise_q) begin
          shift_d = {shift_q[Width-2:0], mosi_q};
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        end
        if (cs_rise_q) state_d = StDecode;
      end
      StDecode: begin
        state_d = StIdle;
        if (cnt_q == CntFull) dec_ok  = 1'b1;
        else                  dec_err = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // ctrl[3] picks the channel, ctrl[0] is write (1) or shutdown (0); ctrl[2:1] are don't-care
  logic             wr_a, wr_b, sd_a, sd_b;
  logic [DataW-1:0] data;

  assign data = shift_q[DataW-1:0];
  assign wr_a = dec_ok & ~shift_q[Width-1] &  shift_q[Width-4];
  assign wr_b = dec_ok &  shift_q[Width-1] &  shift_q[Width-4];
  assign sd_a = dec_ok & ~shift_q[Width-1] & ~shift_q[Width-4];
  assign sd_b = dec_ok &  shift_q[Width-1] & ~shift_q[Width-4];

  logic [DataW-1:0] dcha_q, dcha_d, dchb_q, dchb_d;
  logic             vlda_q, vlda_d, vldb_q, vldb_d;
  logic             shdna_q, shdna_d, shdnb_q, shdnb_d;
  logic             err_q, busy_q;

`ifdef SPI_DAC_RX_LDAC_EN
  logic [DataW-1:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic             pend_a_q, pend_a_d, pend_b_q, pend_b_d;
`endif

  always_comb begin
    dcha_d  = dcha_q;
    dchb_d  = dchb_q;
    vlda_d  = 1'b0;
    vldb_d  = 1'b0;
    shdna_d = shdna_q;
    shdnb_d = shdnb_q;
    if (wr_a) shdna_d = 1'b0;
    if (sd_a) shdna_d = 1'b1;
    if (wr_b) shdnb_d = 1'b0;
    if (sd_b) shdnb_d = 1'b1;
`ifdef SPI_DAC_RX_LDAC_EN
    hold_a_d = wr_a ? data : hold_a_q;
    hold_b_d = wr_b ? data : hold_b_q;
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    // Transfer takes the pre-decode holding values; a coinciding write stays pending
    if (ldac_fall_q) begin
      dcha_d   = hold_a_q;
      dchb_d   = hold_b_q;
      vlda_d   = pend_a_q;
      vldb_d   = pend_b_q;
      pend_a_d = 1'b0;
      pend_b_d = 1'b0;
    end
    if (wr_a) pend_a_d = 1'b1;
    if (wr_b) pend_b_d = 1'b1;
`else
    if (wr_a) dcha_d = data;
    if (wr_b) dchb_d = data;
    vlda_d = wr_a;
    vldb_d = wr_b;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dcha_q  <= '0;
      dchb_q  <= '0;
      vlda_q  <= 1'b0;
      vldb_q  <= 1'b0;
      shdna_q <= 1'b0;
      shdnb_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      dcha_q  <= dcha_d;
      dchb_q  <= dchb_d;
      vlda_q  <= vlda_d;
      vldb_q  <= vldb_d;
      shdna_q <= shdna_d;
      shdnb_q <= shdnb_d;
      err_q   <= dec_err;
      busy_q  <= (state_d == StShift);
    end
  end

`ifdef SPI_DAC_RX_LDAC_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hold_a_q <= '0;
      hold_b_q <= '0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
    end else begin
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
    end
  end
`endif

  assign dcha_o  = dcha_q;
  assign dchb_o  = dchb_q;
  assign vlda_o  = vlda_q;
  assign vldb_o  = vldb_q;
  assign shdna_o = shdna_q;
  assign shdnb_o = shdnb_q;
  assign err_o   = err_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_spi_dac_rx_2ch.sv
// Scoreboard bench for spi_dac_rx_2ch: directed frames push expected events, a monitor checks them.
// Honours SPI_DAC_RX_LDAC_EN when defined.
module tb_spi_dac_rx_2ch;

  localparam int KA = 0;
  localparam int KB = 1;
  localparam int KE = 2;

  typedef struct {
    int         kind;
    logic [11:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [11:0] dcha, dchb;
  logic        vlda, vldb, shdna, shdnb, err, busy;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic both_seen = 1'b0;

  spi_dac_rx_2ch_if spi ();

  spi_dac_rx_2ch #(
    .Width      (16),
    .SyncStages (2)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .spi     (spi),
    .dcha_o  (dcha),
    .dchb_o  (dchb),
    .vlda_o  (vlda),
    .vldb_o  (vldb),
    .shdna_o (shdna),
    .shdnb_o (shdnb),
    .err_o   (err),
    .busy_o  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_evt(input int kind, input logic [11:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per output pulse, in queue order
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (vlda && vldb) both_seen = 1'b1;
      for (int k = 0; k < int'(vlda) + int'(vldb) + int'(err); k++) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse: vlda=%0b vldb=%0b err=%0b, expected none",
                   vlda, vldb, err);
        end else begin
          e = exp_q.pop_front();
          if (e.kind == KA && !(vlda && dcha == e.data)) begin
            n_bad++;
            $display("FAIL vld_a: vlda=%0b dcha=%0h, expected pulse with %0h", vlda, dcha, e.data);
          end else if (e.kind == KB && !(vldb && dchb == e.data)) begin
            n_bad++;
            $display("FAIL vld_b: vldb=%0b dchb=%0h, expected pulse with %0h", vldb, dchb, e.data);
          end else if (e.kind == KE && !err) begin
            n_bad++;
            $display("FAIL err: vlda=%0b vldb=%0b err=0, expected err pulse", vlda, vldb);
          end
        end
      end
    end
  end

  task automatic shift_bits(input logic [31:0] word, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      spi.mosi_i = word[i];
      repeat (3) @(negedge clk);
      spi.sck_i = 1'b1;
      repeat (3) @(negedge clk);
      spi.sck_i = 1'b0;
    end
  endtask

  // gap: extra clk periods with cs high after the frame (1 gives a 2-clk cs-high window)
  task automatic send_frame(input logic [31:0] word, input int nbits, input int gap);
    @(negedge clk);
    spi.cs_i = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(word, nbits - 1, nbits / 2);
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    shift_bits(word, nbits / 2 - 1, 0);
    repeat (3) @(negedge clk);
    spi.cs_i   = 1'b1;
    spi.mosi_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic load_dac();
`ifdef SPI_DAC_RX_LDAC_EN
    @(negedge clk);
    spi.ldac_i = 1'b0;
    repeat (4) @(negedge clk);
    spi.ldac_i = 1'b1;
    repeat (8) @(negedge clk);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    spi.sck_i  = 1'b0;
    spi.cs_i   = 1'b1;
    spi.mosi_i = 1'b0;
`ifdef SPI_DAC_RX_LDAC_EN
    spi.ldac_i = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("rst_dcha", {20'd0, dcha}, 32'd0);
    check("rst_dchb", {20'd0, dchb}, 32'd0);
    check("rst_flags", {26'd0, vlda, vldb, shdna, shdnb, err, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    do_reset();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Single write to channel A
    expect_evt(KA, 12'hABC);
    send_frame(32'h3ABC, 16, 12);
    load_dac();
    check("a_dcha", {20'd0, dcha}, 32'hABC);
    check("a_dchb", {20'd0, dchb}, 32'h0);
    check("a_busy_after", {31'd0, busy}, 32'd0);

    // Back-to-back B then A with a 2-clk cs-high gap
    expect_evt(KB, 12'h123);
    expect_evt(KA, 12'h456);
    send_frame(32'hB123, 16, 1);
    send_frame(32'h3456, 16, 12);
    load_dac();
    check("b2b_dchb", {20'd0, dchb}, 32'h123);
    check("b2b_dcha", {20'd0, dcha}, 32'h456);

    // Shutdown A, then write A clears the flag
    send_frame(32'h2FFF, 16, 12);
    load_dac();
    check("sd_shdna_set", {31'd0, shdna}, 32'd1);
    check("sd_dcha_kept", {20'd0, dcha}, 32'h456);
    check("sd_shdnb_clr", {31'd0, shdnb}, 32'd0);
    expect_evt(KA, 12'h001);
    send_frame(32'h3001, 16, 12);
    load_dac();
    check("wr_shdna_clr", {31'd0, shdna}, 32'd0);
    check("wr_dcha", {20'd0, dcha}, 32'h001);

    // Shutdown B leaves A and dchb alone; a B write clears it
    send_frame(32'h8000, 16, 12);
    load_dac();
    check("sdb_shdnb_set", {31'd0, shdnb}, 32'd1);
    check("sdb_shdna", {31'd0, shdna}, 32'd0);
    check("sdb_dchb_kept", {20'd0, dchb}, 32'h123);
    expect_evt(KB, 12'h7FF);
    send_frame(32'hB7FF, 16, 12);
    load_dac();
    check("wrb_shdnb_clr", {31'd0, shdnb}, 32'd0);
    check("wrb_dchb", {20'd0, dchb}, 32'h7FF);

    // Short and long frames are discarded with an error pulse
    expect_evt(KE, 12'h000);
    send_frame(32'h3ABC, 15, 12);
    expect_evt(KE, 12'h000);
    send_frame(32'h13ABC, 17, 12);
    load_dac();
    check("len_dcha", {20'd0, dcha}, 32'h001);
    check("len_dchb", {20'd0, dchb}, 32'h7FF);

    // Reset mid-frame, then a full frame
    @(negedge clk);
    spi.cs_i = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(32'hB555, 15, 8);
    do_reset();
    expect_evt(KB, 12'h555);
    send_frame(32'hB555, 16, 12);
    load_dac();
    check("rstmid_dchb", {20'd0, dchb}, 32'h555);
    check("rstmid_dcha", {20'd0, dcha}, 32'h0);

`ifdef SPI_DAC_RX_LDAC_EN
    do_reset();
    send_frame(32'h3111, 16, 12);
    send_frame(32'hB222, 16, 12);
    check("ldac_hold_dcha", {20'd0, dcha}, 32'h0);
    check("ldac_hold_dchb", {20'd0, dchb}, 32'h0);
    both_seen = 1'b0;
    expect_evt(KA, 12'h111);
    expect_evt(KB, 12'h222);
    load_dac();
    check("ldac_dcha", {20'd0, dcha}, 32'h111);
    check("ldac_dchb", {20'd0, dchb}, 32'h222);
    check("ldac_same_cycle", {31'd0, both_seen}, 32'd1);
`endif

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
